// File: rtl/sta_cnt_pkg.sv
// ============================================================================
// Module   : sta_cnt_pkg
// Purpose  : Shared defaults, count-mode encoding and lowest-set-bit helper
//            for the sta_counter_bank slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sta_cnt_pkg;

  localparam int NUM_CH_DEF      = 32;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic int lowest_set(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sta_cnt_chan.sv
// ============================================================================
// Module   : sta_cnt_chan
// Purpose  : One up-counter channel: clears when disabled, wraps or saturates
//            at the terminal value, and flags a match while enabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sta_cnt_chan
  import sta_cnt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  input  logic             sat_mode,
  output logic             match
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_term;

  assign w_at_term = (r_cnt == term);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (w_at_term) begin
      if (mode_e'(sat_mode) == MODE_WRAP) r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Gated by en so a parked channel never matches, even against term = 0.
  assign match = en & w_at_term;

endmodule

`default_nettype wire

// File: rtl/sta_counter_bank.sv
// ============================================================================
// Module   : sta_counter_bank
// Purpose  : Bank of NUM_CH synchronised-enable up-counters with registered
//            OR-reduced match output and sticky per-channel hit flags.
//            Optional macro STA_CNT_FIRST_HIT_EN adds first_vld/first_id.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sta_counter_bank
  import sta_cnt_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] cen,
  input  logic [CNT_W-1:0]  term,
  input  logic              sat_mode,
  input  logic              hit_clr,
  output logic              cout,
  output logic [NUM_CH-1:0] hit_vec
`ifdef STA_CNT_FIRST_HIT_EN
  ,
  output logic                                           first_vld,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_id
`endif
);

  localparam int FID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] w_cen_s;
  logic [NUM_CH-1:0] w_match;
  logic [NUM_CH-1:0] r_scount;
  logic [NUM_CH-1:0] r_hit;
  logic              r_cout;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= cen;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_cen_s = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    sta_cnt_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .en       (w_cen_s[i]),
      .term     (term),
      .sat_mode (sat_mode),
      .match    (w_match[i])
    );
  end

  // Set has priority over clear so a hit landing with hit_clr is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scount <= '0;
      r_cout   <= 1'b0;
      r_hit    <= '0;
    end else begin
      r_scount <= w_match;
      r_cout   <= |r_scount;
      r_hit    <= hit_clr ? r_scount : (r_hit | r_scount);
    end
  end

  assign cout    = r_cout;
  assign hit_vec = r_hit;

`ifdef STA_CNT_FIRST_HIT_EN
  logic             r_first_vld;
  logic [FID_W-1:0] r_first_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_first_vld <= 1'b0;
      r_first_id  <= '0;
    end else if ((hit_clr || !r_first_vld) && (|r_scount)) begin
      r_first_vld <= 1'b1;
      r_first_id  <= FID_W'(lowest_set(64'(r_scount)));
    end else if (hit_clr) begin
      r_first_vld <= 1'b0;
      r_first_id  <= '0;
    end
  end

  assign first_vld = r_first_vld;
  assign first_id  = r_first_id;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sta_counter_bank.sv
// ============================================================================
// Module   : tb_sta_counter_bank
// Purpose  : Directed self-checking bench for sta_counter_bank
//            (NUM_CH=16, CNT_W=4, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sta_counter_bank;

  logic        clock;
  logic        reset;
  logic [15:0] cen;
  logic [3:0]  term;
  logic        sat_mode;
  logic        hit_clr;
  logic        cout;
  logic [15:0] hit_vec;
`ifdef STA_CNT_FIRST_HIT_EN
  logic        first_vld;
  logic [3:0]  first_id;
`endif

  int n_cmp;
  int n_fail;

  sta_counter_bank #(
    .NUM_CH      (16),
    .CNT_W       (4),
    .SYNC_STAGES (2)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .cen      (cen),
    .term     (term),
    .sat_mode (sat_mode),
    .hit_clr  (hit_clr),
    .cout     (cout),
    .hit_vec  (hit_vec)
`ifdef STA_CNT_FIRST_HIT_EN
    ,
    .first_vld (first_vld),
    .first_id  (first_id)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cen     = '0;
    hit_clr = 1'b0;
    step(3);
    reset   = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    cen      = '0;
    term     = 4'd0;
    sat_mode = 1'b0;
    hit_clr  = 1'b0;

    // Reset and idle with term = 0: disabled channels must not match.
    step(3);
    check("rst_cout", cout, 0);
    check("rst_hit", hit_vec, 0);
    reset = 1'b0;
    step(6);
    check("idle_cout", cout, 0);
    check("idle_hit", hit_vec, 0);

    // Saturate: term 5, channel 3. cout rises after E8.
    term = 4'd5; sat_mode = 1'b1; cen[3] = 1'b1;
    step(1);
    step(7);
    check("sat_pre", cout, 0);
    step(1);
    check("sat_rise", cout, 1);
    check("sat_hit", hit_vec, 16'h0008);
    step(4);
    check("sat_hold", cout, 1);
    cen[3] = 1'b0;
    step(3);
    check("sat_fall_pre", cout, 1);
    step(1);
    check("sat_fall", cout, 0);
    check("sat_sticky", hit_vec, 16'h0008);
    hit_clr = 1'b1;
    step(1);
    hit_clr = 1'b0;
    check("clr_alone", hit_vec, 0);

    // Wrap: term 3, channel 0. cout pulses after E6, E10, E14.
    do_reset();
    term = 4'd3; sat_mode = 1'b0; cen[0] = 1'b1;
    step(1);
    for (int e = 1; e <= 14; e++) begin
      step(1);
      check($sformatf("wrap_e%0d", e), cout, 64'((e >= 6) && ((e - 6) % 4 == 0)));
    end
    check("wrap_sticky", hit_vec, 16'h0001);

    // Boundary: term = 15 on a 4-bit counter wraps naturally, period 16.
    do_reset();
    term = 4'd15; sat_mode = 1'b0; cen[1] = 1'b1;
    step(1);
    for (int e = 1; e <= 40; e++) begin
      step(1);
      check($sformatf("bnd_e%0d", e), cout, 64'((e == 18) || (e == 34)));
    end
    // Count is 7 here; dropping the enable must clear it.
    cen[1] = 1'b0;
    step(6);
    check("bnd_off", cout, 0);
    cen[1] = 1'b1;
    step(1);
    for (int e = 1; e <= 18; e++) begin
      step(1);
      check($sformatf("bnd_re_e%0d", e), cout, 64'(e == 18));
    end

    // Term lowered below the current count: counter wraps through 0 first.
    do_reset();
    term = 4'd15; sat_mode = 1'b0; cen[2] = 1'b1;
    step(1);
    step(11);
    term = 4'd4;
    for (int e = 12; e <= 24; e++) begin
      step(1);
      check($sformatf("tchg_e%0d", e), cout, 64'(e == 23));
    end

    // Clear race: hit_clr in the cycle scount[5] is high.
    do_reset();
    term = 4'd3; sat_mode = 1'b0; cen[5] = 1'b1;
    step(1);
    step(5);
    check("race_pre", hit_vec, 0);
    hit_clr = 1'b1;
    step(1);
    check("race_set_wins", hit_vec, 16'h0020);
    hit_clr = 1'b0;
    step(1);
    hit_clr = 1'b1;
    step(1);
    hit_clr = 1'b0;
    check("race_clr_alone", hit_vec, 0);

    // Two channels, first-hit capture, then reset mid-count.
    do_reset();
    term = 4'd4; sat_mode = 1'b1; cen[9] = 1'b1; cen[2] = 1'b1;
    step(1);
    step(6);
    check("two_pre", cout, 0);
`ifdef STA_CNT_FIRST_HIT_EN
    check("first_vld_pre", first_vld, 0);
`endif
    step(1);
    check("two_cout", cout, 1);
    check("two_hit", hit_vec, 16'h0204);
`ifdef STA_CNT_FIRST_HIT_EN
    check("first_vld", first_vld, 1);
    check("first_id", first_id, 2);
`endif
    step(2);
    reset = 1'b1;
    step(1);
    check("midrst_cout", cout, 0);
    check("midrst_hit", hit_vec, 0);
`ifdef STA_CNT_FIRST_HIT_EN
    check("midrst_first_vld", first_vld, 0);
    check("midrst_first_id", first_id, 0);
`endif
    // Enables re-propagate through the synchroniser after release.
    reset = 1'b0;
    step(1);
    step(6);
    check("rerun_pre", cout, 0);
    step(1);
    check("rerun_rise", cout, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
